// File: rtl/instruction_set_pkg.sv
// Shared fetch-stage definitions: FSM states, entry format and
// instruction geometry used by the fetch unit and its FIFO.
package instruction_set;

  localparam int INSTR_WORDS = 3;
  localparam int AW = 16;
  localparam int IW = 40;
  localparam int EW = AW + IW;

  localparam logic [1:0] LAST_WORD = 2'(INSTR_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    FULL,
    DISCARD
  } fetch_state_e;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [IW-1:0] instr;
  } fetch_entry_t;

  function automatic logic [AW-1:0] word_addr(
    input logic [AW-1:0] base,
    input logic [1:0]    idx
  );
    return base + 16'(idx);
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch unit bus: control, program-memory port and core handshake.
// master = fetch unit, slave = memory/core side.
interface instr_fetch_unit_if;
  import instruction_set::*;

  logic          fetch_en;
  logic          redirect;
  logic [AW-1:0] redirect_pc;

  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_rvalid;
  logic [15:0]   mem_rdata;

  logic          instr_valid;
  logic          instr_ready;
  logic [IW-1:0] instr;
  logic [AW-1:0] instr_pc;
  logic [AW-1:0] fetch_pc;

  modport master (
    input  fetch_en,
    input  redirect,
    input  redirect_pc,
    input  mem_rvalid,
    input  mem_rdata,
    input  instr_ready,
    output mem_req,
    output mem_addr,
    output instr_valid,
    output instr,
    output instr_pc,
    output fetch_pc
  );

  modport slave (
    output fetch_en,
    output redirect,
    output redirect_pc,
    output mem_rvalid,
    output mem_rdata,
    output instr_ready,
    input  mem_req,
    input  mem_addr,
    input  instr_valid,
    input  instr,
    input  instr_pc,
    input  fetch_pc
  );

endinterface

// File: rtl/instr_fetch_unit_fifo.sv
// Output FIFO of the fetch stage: head read straight from flops,
// synchronous flush, push and pop honoured together even when full.
module fetch_fifo
  import instruction_set::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = EW
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   valid,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q;
  logic [PW-1:0]    rd_q;
  logic [PW:0]      cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= wdata;
        wr_q        <= wr_q + PW'(1);
      end
      if (pop) begin
        rd_q <= rd_q + PW'(1);
      end
      cnt_q <= cnt_q + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

  assign rdata = mem_q[rd_q];
  assign valid = cnt_q != '0;
  assign count = cnt_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: assembles 40-bit instructions from three 16-bit
// memory words, buffers them and hands them to the core.
module instr_fetch_unit
  import instruction_set::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          DEPTH    = 2
) (
  input logic               clk,
  input logic               reset,
  instr_fetch_unit_if.master bus
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  fetch_state_e  state_q;
  fetch_state_e  state_d;
  logic [1:0]    idx_q;
  logic [1:0]    idx_d;
  logic [AW-1:0] pc_q;
  logic [AW-1:0] pc_d;
  logic [7:0]    op_q;
  logic [7:0]    op_d;
  logic [15:0]   mid_q;
  logic [15:0]   mid_d;
  logic          req_q;
  logic          req_d;
  logic [AW-1:0] addr_q;
  logic [AW-1:0] addr_d;

  logic          push;
  logic          pop;
  logic          head_vld;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_np;
  logic          room0;
  logic          room1;
  logic          last;
  logic [AW-1:0] nxt_pc;
  fetch_entry_t  wentry;
  fetch_entry_t  rentry;

  assign pop    = head_vld && bus.instr_ready && !bus.redirect;
  assign cnt_np = cnt - CW'(pop);
  // room0: slot free with no push; room1: still free after a push
  assign room0  = cnt_np != FULL_CNT;
  assign room1  = cnt_np < (FULL_CNT - CW'(1));
  assign last   = idx_q == LAST_WORD;
  assign nxt_pc = pc_q + 16'(INSTR_WORDS);

  assign wentry.pc    = pc_q;
  assign wentry.instr = {op_q, mid_q, bus.mem_rdata};

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pc_d    = pc_q;
    op_d    = op_q;
    mid_d   = mid_q;
    req_d   = req_q;
    addr_d  = addr_q;
    push    = 1'b0;
    if (bus.redirect) begin
      idx_d = '0;
      pc_d  = bus.redirect_pc;
      if (req_q && !bus.mem_rvalid) begin
        state_d = DISCARD;
      end else begin
        state_d = bus.fetch_en ? REQ : IDLE;
        req_d   = bus.fetch_en;
        addr_d  = bus.redirect_pc;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.fetch_en && room0) begin
            state_d = REQ;
            req_d   = 1'b1;
            addr_d  = word_addr(pc_q, idx_q);
          end
        end
        REQ: begin
          if (bus.mem_rvalid) begin
            req_d = 1'b0;
            if (last) begin
              push  = 1'b1;
              idx_d = '0;
              pc_d  = nxt_pc;
              if (!room1) begin
                state_d = FULL;
              end else if (!bus.fetch_en) begin
                state_d = IDLE;
              end else begin
                req_d  = 1'b1;
                addr_d = nxt_pc;
              end
            end else begin
              idx_d = idx_q + 2'd1;
              if (idx_q == 2'd0) begin
                op_d = bus.mem_rdata[7:0];
              end else begin
                mid_d = bus.mem_rdata;
              end
              if (!bus.fetch_en) begin
                state_d = IDLE;
              end else begin
                req_d  = 1'b1;
                addr_d = word_addr(pc_q, idx_q + 2'd1);
              end
            end
          end
        end
        FULL: begin
          if (room0) begin
            state_d = bus.fetch_en ? REQ : IDLE;
            req_d   = bus.fetch_en;
            addr_d  = word_addr(pc_q, idx_q);
          end
        end
        DISCARD: begin
          if (bus.mem_rvalid) begin
            state_d = bus.fetch_en ? REQ : IDLE;
            req_d   = bus.fetch_en;
            addr_d  = pc_q;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      pc_q    <= RESET_PC;
      op_q    <= '0;
      mid_q   <= '0;
      req_q   <= 1'b0;
      addr_q  <= RESET_PC;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pc_q    <= pc_d;
      op_q    <= op_d;
      mid_q   <= mid_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (bus.redirect),
    .push  (push),
    .pop   (pop),
    .wdata (wentry),
    .rdata (rentry),
    .valid (head_vld),
    .count (cnt)
  );

  assign bus.mem_req     = req_q;
  assign bus.mem_addr    = addr_q;
  assign bus.instr_valid = head_vld;
  assign bus.instr       = rentry.instr;
  assign bus.instr_pc    = rentry.pc;
  assign bus.fetch_pc    = pc_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a variable-latency
// single-outstanding program memory model.
module tb_instr_fetch_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int total = 0;
  int bad = 0;

  instr_fetch_unit_if bus();

  instr_fetch_unit #(
    .RESET_PC (16'h0000),
    .DEPTH    (2)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [0:65535];
  int          lat = 1;
  bit          busy = 0;
  int          age = 0;
  logic [15:0] maddr = '0;
  logic [15:0] issued [$];

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // one clock; the memory model reacts to the new DUT outputs
  task automatic tick();
    @(posedge clk);
    #1;
    if (!rst_n) begin
      busy = 0;
      bus.mem_rvalid = 1'b0;
      return;
    end
    if (bus.mem_rvalid) busy = 0;
    if (busy) begin
      age++;
      chk("mem_hold", {bus.mem_req, bus.mem_addr}, {1'b1, maddr});
    end else if (bus.mem_req) begin
      busy = 1;
      age = 0;
      maddr = bus.mem_addr;
      issued.push_back(bus.mem_addr);
    end
    bus.mem_rvalid = busy && (age >= lat);
    bus.mem_rdata = bus.mem_rvalid ? mem[maddr] : 16'h0000;
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n = 0;
    while (bus.instr_valid !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk(tag, bus.instr_valid, 1);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req"}, bus.mem_req, 0);
    chk({tag, "_addr"}, bus.mem_addr, 16'h0000);
    chk({tag, "_vld"}, bus.instr_valid, 0);
    chk({tag, "_instr"}, bus.instr, 40'h0);
    chk({tag, "_ipc"}, bus.instr_pc, 16'h0000);
    chk({tag, "_fpc"}, bus.fetch_pc, 16'h0000);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < 65536; i++) mem[i] = 16'(i) ^ 16'h5A5A;
    mem[16'h0000] = 16'h0011;
    mem[16'h0001] = 16'h1234;
    mem[16'h0002] = 16'h5678;
    mem[16'h0003] = 16'hAB22;
    mem[16'h0004] = 16'h9ABC;
    mem[16'h0005] = 16'hDEF0;
    mem[16'h0006] = 16'h0033;
    mem[16'h0007] = 16'h4444;
    mem[16'h0008] = 16'h5555;
    mem[16'h0100] = 16'hFF77;
    mem[16'h0101] = 16'h0102;
    mem[16'h0102] = 16'h0304;
    mem[16'hFFFE] = 16'h0066;
    mem[16'hFFFF] = 16'h7777;

    bus.fetch_en    = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 16'h0000;
    bus.instr_ready = 1'b0;
    bus.mem_rvalid  = 1'b0;
    bus.mem_rdata   = 16'h0000;

    #2 rst_n = 1'b0;
    #1 chk_reset("rst0");
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    chk("idle_req", bus.mem_req, 0);

    // basic fetch, latency 1
    bus.instr_ready = 1'b1;
    bus.fetch_en = 1'b1;
    tick();
    chk("t1_req", {bus.mem_req, bus.mem_addr}, {1'b1, 16'h0000});
    repeat (5) tick();
    chk("t1_early", bus.instr_valid, 0);
    tick();
    chk("t1_vld", bus.instr_valid, 1);
    chk("t1_instr", bus.instr, 40'h11_1234_5678);
    chk("t1_ipc", bus.instr_pc, 16'h0000);
    repeat (6) tick();
    chk("t1_vld2", bus.instr_valid, 1);
    chk("t1_ipc2", bus.instr_pc, 16'h0003);
    chk("t1_instr2", bus.instr, 40'h22_9ABC_DEF0);
    chk("t1_next", {bus.mem_req, bus.mem_addr}, {1'b1, 16'h0006});
    bus.instr_ready = 1'b0;

    // back-pressure fills the FIFO
    repeat (10) tick();
    chk("t2_req", bus.mem_req, 0);
    chk("t2_vld", bus.instr_valid, 1);
    chk("t2_ipc", bus.instr_pc, 16'h0003);
    chk("t2_fpc", bus.fetch_pc, 16'h0009);
    repeat (3) begin
      tick();
      chk("t2_hold", bus.mem_req, 0);
    end
    bus.instr_ready = 1'b1;
    tick();
    bus.instr_ready = 1'b0;
    chk("t2_resume", {bus.mem_req, bus.mem_addr}, {1'b1, 16'h0009});
    chk("t2_ipc2", bus.instr_pc, 16'h0006);
    chk("t2_instr2", bus.instr, 40'h33_4444_5555);
    bus.instr_ready = 1'b1;
    tick();
    chk("t2_empty", bus.instr_valid, 0);

    // redirect while word 1 outstanding, latency 4
    lat = 4;
    n = 0;
    while (!(busy && age == 1 && maddr == bus.fetch_pc + 16'd1) && n < 40) begin
      tick();
      n++;
    end
    chk("t3_sync", n < 40, 1);
    bus.redirect = 1'b1;
    bus.redirect_pc = 16'h0100;
    tick();
    bus.redirect = 1'b0;
    chk("t3_vld", bus.instr_valid, 0);
    chk("t3_fpc", bus.fetch_pc, 16'h0100);
    chk("t3_stale", {bus.mem_req, bus.mem_addr}, {1'b1, 16'h000A});
    n = 0;
    while (bus.mem_addr !== 16'h0100 && n < 10) begin
      tick();
      n++;
    end
    chk("t3_addr", bus.mem_addr, 16'h0100);
    wait_valid("t3_vld2", 40);
    chk("t3_ipc", bus.instr_pc, 16'h0100);
    chk("t3_instr", bus.instr, 40'h77_0102_0304);
    bus.instr_ready = 1'b0;

    // redirect together with rvalid of word 2 and a pop
    n = 0;
    while (!(bus.mem_rvalid && bus.instr_valid &&
             maddr == bus.fetch_pc + 16'd2) && n < 40) begin
      tick();
      n++;
    end
    chk("t4_sync", n < 40, 1);
    bus.redirect = 1'b1;
    bus.redirect_pc = 16'hFFFE;
    bus.instr_ready = 1'b1;
    lat = 1;
    issued.delete();
    tick();
    bus.redirect = 1'b0;
    chk("t4_vld", bus.instr_valid, 0);
    chk("t4_req", {bus.mem_req, bus.mem_addr}, {1'b1, 16'hFFFE});
    chk("t4_fpc", bus.fetch_pc, 16'hFFFE);

    // address wrap
    wait_valid("t5_vld", 30);
    chk("t5_ipc", bus.instr_pc, 16'hFFFE);
    chk("t5_instr", bus.instr, 40'h66_7777_0011);
    chk("t5_nlog", issued.size() >= 3, 1);
    chk("t5_a0", issued[0], 16'hFFFE);
    chk("t5_a1", issued[1], 16'hFFFF);
    chk("t5_a2", issued[2], 16'h0000);
    tick();
    wait_valid("t5_vld2", 20);
    chk("t5_ipc2", bus.instr_pc, 16'h0001);
    chk("t5_instr2", bus.instr, 40'h34_5678_AB22);

    // fetch_en drop after word 0, then async reset
    n = 0;
    while (!(busy && age == 0 && maddr == bus.fetch_pc) && n < 20) begin
      tick();
      n++;
    end
    chk("t6_sync", n < 20, 1);
    bus.fetch_en = 1'b0;
    repeat (3) tick();
    chk("t6_stop", bus.mem_req, 0);
    chk("t6_fpc", bus.fetch_pc, 16'h0004);
    lat = 4;
    bus.fetch_en = 1'b1;
    tick();
    chk("t6_resume", {bus.mem_req, bus.mem_addr}, {1'b1, 16'h0005});
    tick();
    #2 rst_n = 1'b0;
    #1 chk_reset("rst1");
    #2 rst_n = 1'b1;
    busy = 0;
    bus.mem_rvalid = 1'b0;
    lat = 1;
    tick();
    chk("t6_restart", {bus.mem_req, bus.mem_addr}, {1'b1, 16'h0000});
    wait_valid("t6_vld", 20);
    chk("t6_ipc", bus.instr_pc, 16'h0000);
    chk("t6_instr", bus.instr, 40'h11_1234_5678);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Fetch stage directly upstream of the processor core. Reads 40-bit instructions as three consecutive 16-bit words from program memory and assembles them. Buffers complete instructions in a small FIFO and presents them to the core over a valid/ready handshake. A redirect input supports jumps and calls: it restarts fetch at a new address and flushes everything in flight.

## Interface
- `RESET_PC`, default 16'h0000: first word address fetched after reset.
- `DEPTH`, default 2: output FIFO entries, power of two, ≥2.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `fetch_en` in 1: when low, no new memory request is started; an in-flight request still completes.
- `redirect` in 1: one-cycle pulse; flush and restart at `redirect_pc`.
- `redirect_pc` in 16: word address of the new instruction.
- `mem_req` out 1: memory read request.
- `mem_addr` out 16: word address of the request.
- `mem_rvalid` in 1: read data valid; completes the outstanding request.
- `mem_rdata` in 16: read data.
- `instr_valid` out 1: FIFO head valid.
- `instr_ready` in 1: core accepts the head.
- `instr` out 40: assembled instruction; opcode in [39:32].
- `instr_pc` out 16: word address of the first word of `instr`.
- `fetch_pc` out 16: address of the instruction currently being assembled.

## Operation
- Instruction layout at word address A:
  - mem[A][7:0] → instr[39:32]; mem[A][15:8] is ignored.
  - mem[A+1] → instr[31:16].
  - mem[A+2] → instr[15:0].
  - Next instruction is at A+3. All address arithmetic is 16-bit modulo; 16'hFFFE+3 wraps to 16'h0001.
- At most one memory request is outstanding.
  - A request is issued in the first cycle `mem_req`=1 after reset, or after the cycle in which `mem_rvalid`=1.
  - `mem_req` and `mem_addr` stay stable until `mem_rvalid`.
  - `mem_rvalid` arrives at least 1 cycle after issue.
- FSM states:
  - IDLE: `fetch_en`=0. Go to REQ when `fetch_en`=1 and the FIFO is not full.
  - REQ: request word `idx` (0..2) at `fetch_pc`+`idx`. On `mem_rvalid`, store the word and increment `idx`. When `idx`=2 completes, push {instr, `fetch_pc`} into the FIFO, add 3 to `fetch_pc`, and clear `idx`.
  - FULL: entered if the FIFO is full when a new instruction would start. Leave when an entry pops.
  - DISCARD: wait for the response of a request killed by redirect, drop it, then go to REQ/IDLE.
  - From REQ, a new instruction starts only if the FIFO has room. The FIFO never overflows.
- Redirect has highest priority over everything in the same cycle. On redirect:
  - FIFO is cleared.
  - `idx`=0 and `fetch_pc`=`redirect_pc`.
  - A concurrent pop or push is ignored.
  - If a request is outstanding and `mem_rvalid` is not asserted that same cycle, go to DISCARD.
  - If `mem_rvalid` is asserted that same cycle, its data is dropped and the next cycle issues at `redirect_pc`.
- `fetch_en` falling mid-instruction: finish the outstanding word, then hold `idx` and resume later. No partial instruction is lost.
- Pop happens when `instr_valid` && `instr_ready`. Push and pop in the same cycle are both honoured, including when the FIFO is full.

## Timing
- Reset values:
  - `mem_req`=0, `mem_addr`=`RESET_PC`.
  - `instr_valid`=0, `instr`=0, `instr_pc`=0.
  - `fetch_pc`=`RESET_PC`, FSM=IDLE, FIFO empty.
- All outputs are registered. `instr`/`instr_pc` are the FIFO head and stay stable while `instr_valid`=1 and `instr_ready`=0.
- Best case with memory latency 1, FIFO not full:
  - word issues at t, t+2, t+4;
  - `mem_rvalid` at t+1, t+3, t+5;
  - `instr_valid` at t+6.
  - Sustained rate is one instruction per 6 cycles.
- Redirect at cycle r with no request outstanding: `mem_req`=1, `mem_addr`=`redirect_pc` at r+1, and `instr_valid`=0 from r+1.
- FIFO full → empty slot: the next request issues on the cycle after the pop.
- `reset` asserted mid-transaction: immediate return to reset values. The memory side must tolerate an abandoned request.

## Structure
- Add a fetch-state enum (IDLE/REQ/FULL/DISCARD) to the shared `instruction_set` package.
- Add a constant `INSTR_WORDS` = 3 to the same package.
- One sub-module, `fetch_fifo`: parameterised DEPTH, width 56 ({pc, instr}), with synchronous flush and simultaneous push/pop.

## Test plan
- mem[0]=16'h0011, mem[1]=16'h1234, mem[2]=16'h5678, latency 1, `instr_ready`=1 → `instr`=40'h11_1234_5678 and `instr_pc`=0 at cycle 6 after `fetch_en`; next `instr_pc`=3.
- `instr_ready`=0 with DEPTH=2 → exactly 2 instructions buffered, `mem_req` stays 0. Then raise `instr_ready` → pops in order, fetch resumes the cycle after the first pop.
- Redirect to 16'h0100 while the word-1 request is outstanding at latency 4 → stale response dropped, FIFO empty, next `mem_addr`=16'h0100, first output has `instr_pc`=16'h0100.
- Redirect in the same cycle as `mem_rvalid` and as a pop → nothing pushed, head dropped, `mem_addr`=`redirect_pc` next cycle.
- Redirect to 16'hFFFE → words fetched at FFFE, FFFF, 0000; next `instr_pc`=16'h0001.
- `fetch_en` dropped after word 0, then `reset` pulsed low asynchronously mid-request → all outputs at reset values immediately; after release, fetch restarts at `RESET_PC`.
